// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = x - y - bin, bo is the borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (diff = a - b, LSB first, one bit per clock).
// A single fs_cell is fed from the low bits of two right-shifting operand
// registers; its borrow is registered between cycles.
// Optional macro SERIAL_SUBTRACTOR_BIN_EN adds a borrow-in port 'bin' that
// seeds the initial borrow, so words can be chained via bout -> bin.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BIN_EN
    input  logic             bin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bo;
    logic             borrow_init;

`ifdef SERIAL_SUBTRACTOR_BIN_EN
    assign borrow_init = bin;
`else
    assign borrow_init = 1'b0;
`endif

    fs_cell u_cell (
        .x   (a_sh_q[0]),
        .y   (b_sh_q[0]),
        .bin (borrow_q),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // Next-state logic: load on start, shift one bit per cycle, latch result on the last bit.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = borrow_init;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                res_sh_d = {cell_d, res_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = cell_bo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Result register only moves here, so it stays stable through later SHIFTs.
                    diff_d  = {cell_d, res_sh_q[WIDTH-1:1]};
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status outputs are registered copies of the next state.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected
// {bout,diff} on every accepted start, a negedge monitor pops on done.
module tb_serial_subtractor;

    localparam int W = 8;
`ifdef SERIAL_SUBTRACTOR_BIN_EN
    localparam bit HAS_BIN = 1'b1;
`else
    localparam bit HAS_BIN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_SUBTRACTOR_BIN_EN
        .bin   (bin),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-precision subtraction, bit W of the result is the borrow.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int r;
        r = int'(x) - int'(y) - ((HAS_BIN && bi) ? 1 : 0);
        return (r < 0) ? (W+1)'(r + (1 << (W+1))) : (W+1)'(r);
    endfunction

    // ---------------- monitor ----------------
    logic [W:0] exp_q[$];
    int         done_cyc[$];
    int         mon_checks = 0;
    int         mon_errors = 0;
    int         done_seen  = 0;
    logic [W:0] mexp;

    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            done_cyc.push_back(cyc);
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL unexpected_done: got diff=%h bout=%b, expected no done", diff, bout);
            end else begin
                mexp = exp_q.pop_front();
                if ({bout, diff} !== mexp) begin
                    mon_errors++;
                    $display("FAIL result: got bout=%b diff=%h, expected bout=%b diff=%h",
                             bout, diff, mexp[W], mexp[W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int         s_checks = 0;
    int         s_errors = 0;
    logic [W:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        s_checks++;
        if (act !== expv) begin
            s_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT idle.
    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          input int glitch_at, input int abort_at);
        int nb = 0;
        int n  = 0;
        bit got_done = 0;
        wait_idle();
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        if (abort_at < 0) exp_q.push_back(model(ia, ib, ibin));
        while (n < 40 && !got_done) begin
            start = 1'b0;
            if (busy) begin
                nb++;
                check("diff_held", 32'(diff), 32'(last_res[W-1:0]));
                if (nb == glitch_at) begin
                    start = 1'b1; a = W'($urandom); b = W'($urandom);
                end
                if (nb == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_diff", 32'(diff), 32'd0);
                    check("abort_bout", 32'(bout), 32'd0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    last_res = '0;
                    return;
                end
            end
            if (done) got_done = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 32'd1, 32'd0);
        check("busy_cycles", 32'(nb), 32'(W));
        last_res = model(ia, ib, ibin);
    endtask

    int base;
    int total_checks, total_errors;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'h05, 8'h03, 1'b0, -1, -1);
        run_op(8'h03, 8'h05, 1'b0, -1, -1);
        run_op(8'h00, 8'hFF, 1'b0, -1, -1);
        run_op(8'h80, 8'h01, 1'b0, 3, -1);
        run_op(8'h40, 8'h10, 1'b0, -1, 4);
        repeat (15) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(exp_q.size()), 32'd0);
        run_op(8'h40, 8'h10, 1'b0, -1, -1);
`ifdef SERIAL_SUBTRACTOR_BIN_EN
        run_op(8'h10, 8'h01, 1'b1, -1, -1);
        run_op(8'h00, 8'h00, 1'b1, -1, -1);
`endif

        // Start held high: three back-to-back operations, one every W+2 cycles.
        wait_idle();
        base = done_seen;
        a = 8'hAA; b = 8'hAA; bin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back(model(8'hAA, 8'hAA, 1'b0));
        repeat (21) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("held_done_count", 32'(done_seen - base), 32'd3);
        if (done_cyc.size() >= 3) begin
            check("held_period1", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'(W + 2));
            check("held_period2", 32'(done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3]), 32'(W + 2));
        end else begin
            check("held_done_log", 32'(done_cyc.size()), 32'd3);
        end
        last_res = model(8'hAA, 8'hAA, 1'b0);

        // Randomized operations with occasional ignored starts while busy.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rbin;
            int g;
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) begin ra = '0; rb = '1; end
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W - 1)) : -1;
            run_op(ra, rb, rbin, g, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (15) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        total_checks = s_checks + mon_checks;
        total_errors = s_errors + mon_errors;
        $display("CHECKS %0d ERRORS %0d", total_checks, total_errors);
        $finish;
    end

endmodule
